// File: rtl/gate_exerciser_if.sv
// Link between the exerciser and a two-input gate under test.
//   A, B : operands driven by the exerciser
//   Y    : result returned by the gate
// master = exerciser side, slave = gate-under-test side.
interface gate_exerciser_if;
  logic A;
  logic B;
  logic Y;

  modport master (output A, output B, input Y);
  modport slave  (input A, input B, output Y);
endinterface

// File: rtl/gate_exerciser.sv
// Applies the four input vectors {A,B} = 00,10,01,11 to a two-input gate.
// Each vector is held for HOLD_CYCLES cycles. Y is checked against TRUTH on
// the last cycle of each hold, and the mismatches are collected.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : run request, honoured only when idle
//   gate      : A/B operands out, Y result in (master modport)
//   busy      : high while vectors are being applied
//   done      : one-cycle pulse when a run completes
//   pass      : last run had no mismatches; held until the next start
//   err_count : mismatch count of the current or last run (0..4)
//   fail_vec  : bit i set when vector i mismatched
module gate_exerciser #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [3:0]  TRUTH       = 4'b1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gate_exerciser_if.master    gate,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2:0]          err_count,
  output logic [3:0]          fail_vec
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_N = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_N-1:0]   fail_q, fail_d;
  logic [IDX_W-1:0]   idx_nxt_c;

  assign idx_nxt_c = idx_q + IDX_W'(1);

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end

      DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          // Y is sampled only on the last cycle of the hold.
          if (gate.Y != TRUTH[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + ERR_W'(1);
          end
          cnt_d = '0;
          if (idx_q != IDX_W'(3)) begin
            idx_d = idx_nxt_c;
            a_d   = idx_nxt_c[0];
            b_d   = idx_nxt_c[1];
          end else begin
            // The pass decision includes a mismatch found on this same edge.
            state_d = DONE;
            idx_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign gate.A    = a_q;
  assign gate.B    = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 20, giving the cycles each input vector is held; the legal range SHALL be 2..255.
REQ-002 The block SHALL have parameter TRUTH, default 4'b1000 (AND), a 4-bit expected truth table where bit i is the expected Y for vector index i.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, width 1: a run request, sampled only in IDLE.
REQ-006 The block SHALL have port A, output, width 1: the first operand driven to the gate under test, registered.
REQ-007 The block SHALL have port B, output, width 1: the second operand driven to the gate under test, registered.
REQ-008 The block SHALL have port Y, input, width 1: the result returned by the gate under test.
REQ-009 The block SHALL have port busy, output, width 1: high while vectors are being applied.
REQ-010 The block SHALL have port done, output, width 1: a one-cycle pulse at the end of a run.
REQ-011 The block SHALL have port pass, output, width 1: high when the last run had zero mismatches; it SHALL hold until the next run starts.
REQ-012 The block SHALL have port err_count, output, width 3: the number of mismatches in the current or last run (0..4).
REQ-013 The block SHALL have port fail_vec, output, width 4: bit i set when vector i mismatched.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, DRIVE and DONE, with an 8-bit hold counter cnt and a 2-bit vector index i.
REQ-015 For vector index i, the block SHALL drive A = i[0] and B = i[1]; the order SHALL be {A,B} = 00, 10, 01, 11, and the expected Y SHALL be TRUTH[i].
REQ-016 In IDLE, the block SHALL drive A = 0, B = 0 and busy = 0.
REQ-017 On an edge with state IDLE and start = 1, the block SHALL enter DRIVE with i = 0 and cnt = 0, set busy = 1, and clear pass, err_count and fail_vec.
REQ-018 In DRIVE, cnt SHALL increment by 1 per cycle, and A/B SHALL stay constant for HOLD_CYCLES cycles per vector.
REQ-019 On the edge where cnt == HOLD_CYCLES-1, Y SHALL be compared with TRUTH[i]; on a mismatch, fail_vec[i] SHALL be set and err_count SHALL be incremented at that same edge.
REQ-020 At that same edge, if i < 3, the block SHALL advance i, reset cnt to 0 and drive the new vector.
REQ-021 At that same edge, if i == 3, the block SHALL go to DONE, set busy = 0, set done = 1, and set pass = 1 if and only if the final err_count is 0, including a mismatch detected at this edge.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE with done = 0.
REQ-023 Latency: with start sampled at edge k, busy SHALL be high after edges k..k+4*HOLD_CYCLES-1 and done SHALL be high only after edge k+4*HOLD_CYCLES.
REQ-024 start SHALL be ignored in DRIVE and DONE, with no restart and no effect on the counters.
REQ-025 err_count SHALL never wrap, since its maximum is 4 and it fits in 3 bits.
REQ-026 Y SHALL be sampled only at the compare edge; glitches on Y at other cycles SHALL have no effect.

Reset
REQ-027 On a rising edge with rst = 1, the block SHALL enter IDLE with i = 0, cnt = 0, A = 0, B = 0, busy = 0, done = 0, pass = 0, err_count = 0 and fail_vec = 0, regardless of state.
REQ-028 rst SHALL take priority over start at the same edge.
REQ-029 A reset mid-run SHALL abort the run, and no done pulse SHALL be produced for it.

Verification
REQ-030 A bench SHALL cover: Y = A&B, default parameters, start pulse -> A/B sequence 00,10,01,11 at 20 cycles each; done pulses 80 cycles after the start edge; pass = 1, err_count = 0, fail_vec = 0000.
REQ-031 A bench SHALL cover: Y tied 0 -> pass = 0, err_count = 1, fail_vec = 1000.
REQ-032 A bench SHALL cover: Y tied 1 -> pass = 0, err_count = 3, fail_vec = 0111.
REQ-033 A bench SHALL cover: TRUTH = 4'b1110 with Y = A|B, HOLD_CYCLES = 2 -> done 8 cycles after start; pass = 1.
REQ-034 A bench SHALL cover: start pulsed again during DRIVE (vector 1) -> the sequence is unaltered and exactly one done pulse occurs.
REQ-035 A bench SHALL cover: rst asserted during vector 2 with Y tied 0 -> the next edge gives all outputs at reset values, no done pulse, and A = B = 0 until the next start.
